// File: rtl/systolic_seq_ctrl_if.sv
// systolic_seq_ctrl_if: command (start, k_len, abort) and array-control (busy, pe_clear, lane_valid, lane_k, capture, done) bundle
interface systolic_seq_ctrl_if #(parameter int N = 4, parameter int KW = 4);
  logic start;
  logic [KW-1:0] k_len;
  logic abort;
  logic busy;
  logic pe_clear;
  logic [N-1:0] lane_valid;
  logic [N*KW-1:0] lane_k;
  logic capture;
  logic done;
  modport master (output start, k_len, abort, input busy, pe_clear, lane_valid, lane_k, capture, done);
  modport slave (input start, k_len, abort, output busy, pe_clear, lane_valid, lane_k, capture, done);
endinterface

// File: rtl/systolic_seq_ctrl.sv
// systolic_seq_ctrl: clear/skewed-feed/drain/capture sequencer for an NxN output-stationary array; ports clk, async active-low reset, bus (slave: start/k_len/abort in, busy/pe_clear/lane_valid/lane_k/capture/done out)
module systolic_seq_ctrl #(
  parameter int N = 4,
  parameter int KW = 4
) (
  input logic clk,
  input logic reset,
  systolic_seq_ctrl_if.slave bus
);
  localparam int TW = KW + $clog2(N) + 1;
  typedef enum logic [2:0] {IDLE, CLEAR, FEED, DRAIN, CAPTURE, DONE} state_t;
  state_t state;
  logic [TW-1:0] t, tn, t_last, d;
  logic [KW-1:0] k;
  logic [N-1:0] lv_n;
  logic [N*KW-1:0] lk_n;
  assign tn = state == CLEAR ? '0 : t + TW'(1);
  assign t_last = TW'(k) + TW'(N - 2);
  always_comb begin
    lv_n = '0;
    lk_n = '0;
    d = '0;
    for (int i = 0; i < N; i++) begin
      d = tn - TW'(i);
      lv_n[i] = tn >= TW'(i) && d < TW'(k);
      lk_n[i*KW +: KW] = lv_n[i] ? d[KW-1:0] : '0;
    end
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      t <= '0;
      k <= '0;
      bus.busy <= 1'b0;
      bus.pe_clear <= 1'b1;
      bus.lane_valid <= '0;
      bus.lane_k <= '0;
      bus.capture <= 1'b0;
      bus.done <= 1'b0;
    end else if (bus.abort && state != IDLE) begin
      state <= IDLE;
      t <= '0;
      bus.busy <= 1'b0;
      bus.pe_clear <= 1'b1;
      bus.lane_valid <= '0;
      bus.lane_k <= '0;
      bus.capture <= 1'b0;
      bus.done <= 1'b0;
    end else begin
      case (state)
        IDLE: if (bus.start) begin
          state <= CLEAR;
          k <= bus.k_len;
          bus.busy <= 1'b1;
        end
        CLEAR: begin
          t <= '0;
          bus.pe_clear <= 1'b0;
          state <= k != '0 ? FEED : CAPTURE;
          bus.capture <= k == '0;
          bus.lane_valid <= lv_n;
          bus.lane_k <= lk_n;
        end
        FEED: begin
          // lv_n is naturally all-zero once tn passes t_last, so the lanes close by themselves
          bus.lane_valid <= lv_n;
          bus.lane_k <= lk_n;
          t <= t == t_last ? '0 : tn;
          state <= t == t_last ? DRAIN : FEED;
        end
        DRAIN: begin
          t <= t + TW'(1);
          state <= t == TW'(N - 2) ? CAPTURE : DRAIN;
          bus.capture <= t == TW'(N - 2);
        end
        CAPTURE: begin
          bus.capture <= 1'b0;
          bus.done <= 1'b1;
          state <= DONE;
        end
        DONE: begin
          bus.done <= 1'b0;
          bus.busy <= 1'b0;
          bus.pe_clear <= 1'b1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_systolic_seq_ctrl.sv
// tb_systolic_seq_ctrl: randomized scoreboard bench driving the sequencer into a behavioural PE array
module tb_systolic_seq_ctrl;
  localparam int N = 4;
  localparam int KW = 4;
  localparam int KM = 16;
  logic clk = 0;
  logic reset = 1;
  systolic_seq_ctrl_if #(.N(N), .KW(KW)) bus();
  systolic_seq_ctrl #(.N(N), .KW(KW)) dut (.clk(clk), .reset(reset), .bus(bus));
  always #5 clk = ~clk;
  typedef struct {
    int cyc;
    logic [N-1:0] lv;
    logic [N*KW-1:0] lk;
    logic cap;
    logic dn;
  } ev_t;
  ev_t q[$];
  int total = 0, bad = 0, cyc = 0, bf = -1, bt = -2;
  logic [7:0] ma[N][KM], mb[KM][N], fa[N], fb[N], ar[N][N], br[N][N];
  logic [31:0] acc[N][N], exp_c[N][N];
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s cyc=%0d got=%0h want=%0h", nm, cyc, act, want);
    end
  endtask
  always @(posedge clk) cyc <= cyc + 1;
  always_comb
    for (int i = 0; i < N; i++) begin
      fa[i] = bus.lane_valid[i] ? ma[i][bus.lane_k[i*KW +: KW]] : 8'd0;
      fb[i] = bus.lane_valid[i] ? mb[bus.lane_k[i*KW +: KW]][i] : 8'd0;
    end
  function automatic logic [7:0] pa(input int i, input int j);
    return j == 0 ? fa[i] : ar[i][(j == 0) ? 0 : j - 1];
  endfunction
  function automatic logic [7:0] pb(input int i, input int j);
    return i == 0 ? fb[j] : br[(i == 0) ? 0 : i - 1][j];
  endfunction
  always @(posedge clk)
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) begin
        acc[i][j] <= bus.pe_clear ? 32'd0 : acc[i][j] + 32'(pa(i, j)) * 32'(pb(i, j));
        ar[i][j] <= bus.pe_clear ? 8'd0 : pa(i, j);
        br[i][j] <= bus.pe_clear ? 8'd0 : pb(i, j);
      end
  task automatic accept(input int c0, input int k);
    logic [N-1:0] lv[64];
    logic [N*KW-1:0] lk[64];
    int fin;
    for (int t = 0; t < 64; t++) begin
      lv[t] = '0;
      lk[t] = '0;
    end
    for (int kk = 0; kk < k; kk++)
      for (int i = 0; i < N; i++) begin
        lv[kk+i][i] = 1'b1;
        lk[kk+i][i*KW +: KW] = KW'(kk);
      end
    for (int t = 0; t < (k > 0 ? k + N - 1 : 0); t++) q.push_back('{c0 + 2 + t, lv[t], lk[t], 1'b0, 1'b0});
    fin = k > 0 ? c0 + k + 2 * N : c0 + 2;
    q.push_back('{fin, '0, '0, 1'b1, 1'b0});
    q.push_back('{fin + 1, '0, '0, 1'b0, 1'b1});
    bf = c0 + 1;
    bt = fin + 1;
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) begin
        exp_c[i][j] = 0;
        for (int kk = 0; kk < k; kk++) exp_c[i][j] += 32'(ma[i][kk]) * 32'(mb[kk][j]);
      end
  endtask
  always @(negedge clk)
    if (reset) begin
      if (bus.abort && cyc >= bf && cyc <= bt) begin
        while (q.size() > 0 && q[$].cyc > cyc) void'(q.pop_back());
        bt = cyc;
      end else if (bus.start && !(cyc >= bf && cyc <= bt)) accept(cyc, int'(bus.k_len));
    end
  always @(negedge clk) begin : mon
    logic eb;
    ev_t e;
    eb = cyc >= bf && cyc <= bt;
    chk("busy", bus.busy, eb);
    chk("pe_clear", bus.pe_clear, !eb || cyc == bf);
    while (q.size() > 0 && q[0].cyc < cyc) begin
      total++;
      bad++;
      $display("FAIL missing_event cyc=%0d want_at=%0d lv=%0h cap=%0b done=%0b", cyc, q[0].cyc, q[0].lv, q[0].cap, q[0].dn);
      void'(q.pop_front());
    end
    if (|bus.lane_valid || bus.capture || bus.done) begin
      if (q.size() == 0 || q[0].cyc != cyc) begin
        total++;
        bad++;
        $display("FAIL unexpected_output cyc=%0d lv=%0h cap=%0b done=%0b", cyc, bus.lane_valid, bus.capture, bus.done);
      end else begin
        e = q.pop_front();
        chk("lane_valid", bus.lane_valid, e.lv);
        chk("lane_k", bus.lane_k, e.lk);
        chk("capture", bus.capture, e.cap);
        chk("done", bus.done, e.dn);
        if (e.cap)
          for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++) chk($sformatf("result[%0d][%0d]", i, j), acc[i][j], exp_c[i][j]);
      end
    end
  end
  task automatic rand_mats();
    for (int i = 0; i < N; i++)
      for (int k = 0; k < KM; k++) begin
        ma[i][k] = 8'($urandom_range(0, 255));
        mb[k][i] = 8'($urandom_range(0, 255));
      end
  endtask
  task automatic pulse(input int k);
    bus.k_len = KW'(k);
    bus.start = 1'b1;
    @(posedge clk);
    #1 bus.start = 1'b0;
  endtask
  task automatic wait_idle();
    for (int n = 0; n < 200; n++) begin
      @(negedge clk);
      if (!bus.busy) begin
        @(posedge clk);
        #1;
        return;
      end
    end
    total++;
    bad++;
    $display("FAIL idle_timeout cyc=%0d busy=%0b", cyc, bus.busy);
  endtask
  task automatic op(input int k);
    pulse(k);
    wait_idle();
  endtask
  task automatic chk_idle_outputs(input string tag);
    chk({tag, "_busy"}, bus.busy, 1'b0);
    chk({tag, "_pe_clear"}, bus.pe_clear, 1'b1);
    chk({tag, "_lane_valid"}, bus.lane_valid, '0);
    chk({tag, "_lane_k"}, bus.lane_k, '0);
    chk({tag, "_capture"}, bus.capture, 1'b0);
    chk({tag, "_done"}, bus.done, 1'b0);
  endtask
  initial begin
    bus.start = 1'b0;
    bus.abort = 1'b0;
    bus.k_len = '0;
    #1 reset = 1'b0;
    #1 chk_idle_outputs("reset");
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    repeat (5) @(posedge clk);
    #1 rand_mats();
    op(3);
    for (int i = 0; i < N; i++)
      for (int k = 0; k < KM; k++) begin
        ma[i][k] = 8'(i == k);
        mb[k][i] = 8'(k * 4 + i);
      end
    op(4);
    op(4);
    op(0);
    rand_mats();
    pulse(5);
    repeat (3) @(posedge clk);
    #1 bus.abort = 1'b1;
    @(posedge clk);
    #1 bus.abort = 1'b0;
    chk_idle_outputs("abort");
    wait_idle();
    op(5);
    rand_mats();
    pulse(2);
    repeat (7) @(posedge clk);
    #1 bus.start = 1'b1;
    @(posedge clk);
    #1 bus.start = 1'b0;
    repeat (2) @(posedge clk);
    #1 bus.start = 1'b1;
    repeat (2) @(posedge clk);
    #1 bus.start = 1'b0;
    wait_idle();
    for (int r = 0; r < 25; r++) begin
      int k;
      rand_mats();
      k = $urandom_range(0, 15);
      pulse(k);
      if ($urandom_range(0, 1) == 1) begin
        bus.k_len = KW'($urandom);
        bus.start = 1'b1;
        @(posedge clk);
        #1 bus.start = 1'b0;
      end
      if ($urandom_range(0, 3) == 0) begin
        repeat ($urandom_range(0, k + 8)) @(posedge clk);
        #1 bus.abort = 1'b1;
        @(posedge clk);
        #1 bus.abort = 1'b0;
      end
      wait_idle();
    end
    rand_mats();
    pulse(6);
    repeat (3) @(posedge clk);
    #2 reset = 1'b0;
    #1 chk_idle_outputs("async_reset");
    q.delete();
    bt = cyc - 1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    op(6);
    repeat (5) @(posedge clk);
    #1 chk("queue_drained", q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
